// File: rtl/prog_launch_seq.sv
// ---------------------------------------------------------------------------
// prog_launch_seq
//
// Program launch sequencer placed directly upstream of the CPU core. A bench
// level init pulse becomes a per-program start command (start address plus a
// one-cycle start strobe). The block then waits for the core's halt flag. In
// run-all mode it chains programs 0, 1 and 2 back to back. When the sequence
// ends it raises a single done, and it records a cycle count for each
// program.
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   reset      in   synchronous active-low reset (0 = reset)
//   init       in   launch request; a rise arms, a fall launches
//   prog_sel   in   0/1/2 = run that program alone, 3 = run all three
//   core_done  in   core halt flag (level), only looked at while running
//   core_start out  one-cycle strobe telling the core to load start_pc
//   start_pc   out  start address of the current program
//   prog_idx   out  index of the program launched or running (0..2)
//   busy       out  high while launching, running or advancing
//   done       out  sequence finished, held until the next init rise
//   cyc0..cyc2 out  cycle count of the last completed run of each program
// ---------------------------------------------------------------------------
module prog_launch_seq #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned PC0   = 0,
  parameter int unsigned PC1   = 64,
  parameter int unsigned PC2   = 128,
  parameter int unsigned CYC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic [1:0]       prog_sel,
  input  logic             core_done,
  output logic             core_start,
  output logic [PC_W-1:0]  start_pc,
  output logic [1:0]       prog_idx,
  output logic             busy,
  output logic             done,
  output logic [CYC_W-1:0] cyc0,
  output logic [CYC_W-1:0] cyc1,
  output logic [CYC_W-1:0] cyc2
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_LAUNCH,
    S_RUN,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [PC_W-1:0]  PC0_V   = PC_W'(PC0);
  localparam logic [PC_W-1:0]  PC1_V   = PC_W'(PC1);
  localparam logic [PC_W-1:0]  PC2_V   = PC_W'(PC2);
  localparam logic [CYC_W-1:0] CYC_MAX = '1;

  state_t           state_q, state_d;
  logic             init_q;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       idx_q, idx_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic [CYC_W-1:0] cyc0_q, cyc0_d;
  logic [CYC_W-1:0] cyc1_q, cyc1_d;
  logic [CYC_W-1:0] cyc2_q, cyc2_d;

  logic             init_fall;
  logic             init_rise;
  logic [CYC_W-1:0] cnt_inc;
  logic             capture;

  // Edge detection on init against its value from the previous cycle. The
  // history register keeps tracking init even while busy, so a pulse during
  // a run is simply forgotten rather than replayed afterwards.
  assign init_fall = init_q & ~init;
  assign init_rise = ~init_q & init;

  // Saturating counter+1. Used both as the next counter value in RUN and as
  // the value latched on completion, so a halt in the first RUN cycle gives 1.
  assign cnt_inc = (cnt_q == CYC_MAX) ? CYC_MAX : cnt_q + 1'b1;

  // State and datapath registers. Reset returns everything to its idle
  // values from any state, including the middle of a run, which also clears
  // the recorded cycle counts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      init_q  <= 1'b0;
      mode_q  <= 2'd0;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      cyc0_q  <= '0;
      cyc1_q  <= '0;
      cyc2_q  <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      cyc0_q  <= cyc0_d;
      cyc1_q  <= cyc1_d;
      cyc2_q  <= cyc2_d;
    end
  end

  // Next-state logic. An init fall in IDLE or ARM starts a sequence and
  // captures the mode; a fall seen directly in IDLE covers init that was
  // already high when the block came out of reset. RUN counts cycles until
  // the core halts, and NEXT either chains the following program (run-all
  // mode) or finishes.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cyc0_d  = cyc0_q;
    cyc1_d  = cyc1_q;
    cyc2_d  = cyc2_q;
    capture = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (init_fall) begin
          capture = 1'b1;
        end else if (init_rise) begin
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (init_fall) begin
          capture = 1'b1;
        end
      end
      S_LAUNCH: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (core_done) begin
          case (idx_q)
            2'd0:    cyc0_d = cnt_inc;
            2'd1:    cyc1_d = cnt_inc;
            default: cyc2_d = cnt_inc;
          endcase
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if ((mode_q == 2'd3) && (idx_q < 2'd2)) begin
          idx_d   = idx_q + 2'd1;
          cnt_d   = '0;
          state_d = S_LAUNCH;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (init_rise) begin
          state_d = S_ARM;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (capture) begin
      mode_d  = prog_sel;
      idx_d   = (prog_sel == 2'd3) ? 2'd0 : prog_sel;
      cnt_d   = '0;
      state_d = S_LAUNCH;
    end
  end

  // Start address follows the program index, so it is valid during the
  // strobe and stays stable for the whole run.
  always_comb begin
    case (idx_q)
      2'd0:    start_pc = PC0_V;
      2'd1:    start_pc = PC1_V;
      default: start_pc = PC2_V;
    endcase
  end

  // Status outputs decoded directly from the state register; LAUNCH lasts
  // exactly one cycle, so the strobe is one cycle wide by construction.
  assign core_start = (state_q == S_LAUNCH);
  assign busy       = (state_q == S_LAUNCH) || (state_q == S_RUN) || (state_q == S_NEXT);
  assign done       = (state_q == S_DONE);
  assign prog_idx   = idx_q;
  assign cyc0       = cyc0_q;
  assign cyc1       = cyc1_q;
  assign cyc2       = cyc2_q;

endmodule

// File: tb/tb_prog_launch_seq.sv
// ---------------------------------------------------------------------------
// tb_prog_launch_seq
//
// Directed bench for prog_launch_seq. Two instances share all inputs: one
// with 16-bit cycle counters and one with 4-bit counters so that counter
// saturation can be observed. Inputs change and outputs are sampled 1 ns
// after each rising edge.
// ---------------------------------------------------------------------------
module tb_prog_launch_seq;

  logic        clk;
  logic        reset;
  logic        init;
  logic [1:0]  prog_sel;
  logic        core_done;

  logic        core_start;
  logic [9:0]  start_pc;
  logic [1:0]  prog_idx;
  logic        busy;
  logic        done;
  logic [15:0] cyc0, cyc1, cyc2;

  logic        core_start4;
  logic [9:0]  start_pc4;
  logic [1:0]  prog_idx4;
  logic        busy4;
  logic        done4;
  logic [3:0]  cyc0s, cyc1s, cyc2s;

  int checkCount = 0;
  int errorCount = 0;

  prog_launch_seq dut (
    .clk(clk), .reset(reset), .init(init), .prog_sel(prog_sel), .core_done(core_done),
    .core_start(core_start), .start_pc(start_pc), .prog_idx(prog_idx), .busy(busy),
    .done(done), .cyc0(cyc0), .cyc1(cyc1), .cyc2(cyc2)
  );

  prog_launch_seq #(.CYC_W(4)) dut4 (
    .clk(clk), .reset(reset), .init(init), .prog_sel(prog_sel), .core_done(core_done),
    .core_start(core_start4), .start_pc(start_pc4), .prog_idx(prog_idx4), .busy(busy4),
    .done(done4), .cyc0(cyc0s), .cyc1(cyc1s), .cyc2(cyc2s)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the rising edge.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // init rise then fall; returns in the cycle where the strobe should be up.
  task automatic applyLaunch(input logic [1:0] sel);
    prog_sel = sel;
    init = 1'b1;
    stepClock();
    init = 1'b0;
    stepClock();
  endtask

  // Called in the LAUNCH cycle: raise core_done lat cycles after the strobe,
  // hold it for one edge, and return in the NEXT cycle.
  task automatic applyCoreDone(input int lat);
    repeat (lat) stepClock();
    core_done = 1'b1;
    stepClock();
    core_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; init = 1'b0; prog_sel = 2'd0; core_done = 1'b0;
    stepClock();
    stepClock();
    checkCount++; if (core_start !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_ctrl: got start=%0b busy=%0b done=%0b want 0/0/0", core_start, busy, done); end
    checkCount++; if (start_pc !== 10'd0 || prog_idx !== 2'd0) begin errorCount++; $display("[TB] FAIL reset_pc: got pc=%0d idx=%0d want 0/0", start_pc, prog_idx); end
    checkCount++; if (cyc0 !== 16'd0 || cyc1 !== 16'd0 || cyc2 !== 16'd0) begin errorCount++; $display("[TB] FAIL reset_cyc: got %0d/%0d/%0d want 0/0/0", cyc0, cyc1, cyc2); end
    reset = 1'b1;
    stepClock();
    checkCount++; if (busy !== 1'b0 || done !== 1'b0 || core_start !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_release: got busy=%0b done=%0b start=%0b want 0/0/0", busy, done, core_start); end
  endtask

  task automatic test_single();
    applyLaunch(2'd0);
    checkCount++; if (core_start !== 1'b1) begin errorCount++; $display("[TB] FAIL single_strobe: got %0b want 1", core_start); end
    checkCount++; if (start_pc !== 10'd0 || prog_idx !== 2'd0 || busy !== 1'b1) begin errorCount++; $display("[TB] FAIL single_launch: got pc=%0d idx=%0d busy=%0b want 0/0/1", start_pc, prog_idx, busy); end
    stepClock();
    checkCount++; if (core_start !== 1'b0 || start_pc !== 10'd0) begin errorCount++; $display("[TB] FAIL single_strobe_width: got start=%0b pc=%0d want 0/0", core_start, start_pc); end
    applyCoreDone(9);
    checkCount++; if (done !== 1'b0 || busy !== 1'b1) begin errorCount++; $display("[TB] FAIL single_next: got done=%0b busy=%0b want 0/1", done, busy); end
    stepClock();
    checkCount++; if (done !== 1'b1 || busy !== 1'b0) begin errorCount++; $display("[TB] FAIL single_done: got done=%0b busy=%0b want 1/0", done, busy); end
    checkCount++; if (cyc0 !== 16'd10 || cyc1 !== 16'd0 || cyc2 !== 16'd0) begin errorCount++; $display("[TB] FAIL single_cyc: got %0d/%0d/%0d want 10/0/0", cyc0, cyc1, cyc2); end
  endtask

  task automatic test_run_all();
    int lat[3];
    logic [9:0] pcExp[3];
    lat = '{7, 20, 33};
    pcExp = '{10'd0, 10'd64, 10'd128};
    applyLaunch(2'd3);
    for (int p = 0; p < 3; p++) begin
      checkCount++; if (core_start !== 1'b1 || start_pc !== pcExp[p] || prog_idx !== 2'(p)) begin errorCount++; $display("[TB] FAIL runall_launch%0d: got start=%0b pc=%0d idx=%0d want 1/%0d/%0d", p, core_start, start_pc, prog_idx, pcExp[p], p); end
      applyCoreDone(lat[p]);
      checkCount++; if (done !== 1'b0 || core_start !== 1'b0) begin errorCount++; $display("[TB] FAIL runall_next%0d: got done=%0b start=%0b want 0/0", p, done, core_start); end
      stepClock();
    end
    checkCount++; if (done !== 1'b1 || busy !== 1'b0) begin errorCount++; $display("[TB] FAIL runall_done: got done=%0b busy=%0b want 1/0", done, busy); end
    checkCount++; if (cyc0 !== 16'd7 || cyc1 !== 16'd20 || cyc2 !== 16'd33) begin errorCount++; $display("[TB] FAIL runall_cyc: got %0d/%0d/%0d want 7/20/33", cyc0, cyc1, cyc2); end
  endtask

  task automatic test_ignored_init();
    logic sawStart;
    sawStart = 1'b0;
    applyLaunch(2'd1);
    checkCount++; if (core_start !== 1'b1 || start_pc !== 10'd64) begin errorCount++; $display("[TB] FAIL ign_launch: got start=%0b pc=%0d want 1/64", core_start, start_pc); end
    stepClock();
    init = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i == 3) init = 1'b0;
      stepClock();
      if (core_start === 1'b1 || busy !== 1'b1) sawStart = 1'b1;
    end
    checkCount++; if (sawStart !== 1'b0) begin errorCount++; $display("[TB] FAIL ign_no_restart: got restart/abort=1 want 0"); end
    core_done = 1'b1;
    stepClock();
    core_done = 1'b0;
    stepClock();
    checkCount++; if (done !== 1'b1 || prog_idx !== 2'd1) begin errorCount++; $display("[TB] FAIL ign_done: got done=%0b idx=%0d want 1/1", done, prog_idx); end
    checkCount++; if (cyc1 !== 16'd12 || cyc0 !== 16'd7 || cyc2 !== 16'd33) begin errorCount++; $display("[TB] FAIL ign_cyc: got %0d/%0d/%0d want 7/12/33", cyc0, cyc1, cyc2); end
  endtask

  task automatic test_relaunch();
    prog_sel = 2'd2;
    init = 1'b1;
    stepClock();
    checkCount++; if (done !== 1'b0 || busy !== 1'b0) begin errorCount++; $display("[TB] FAIL relaunch_drop: got done=%0b busy=%0b want 0/0", done, busy); end
    init = 1'b0;
    stepClock();
    checkCount++; if (core_start !== 1'b1 || start_pc !== 10'd128 || prog_idx !== 2'd2) begin errorCount++; $display("[TB] FAIL relaunch_launch: got start=%0b pc=%0d idx=%0d want 1/128/2", core_start, start_pc, prog_idx); end
    applyCoreDone(4);
    stepClock();
    checkCount++; if (done !== 1'b1 || cyc2 !== 16'd4 || cyc0 !== 16'd7 || cyc1 !== 16'd12) begin errorCount++; $display("[TB] FAIL relaunch_cyc: got done=%0b cyc=%0d/%0d/%0d want 1/7/12/4", done, cyc0, cyc1, cyc2); end
  endtask

  task automatic test_saturation();
    applyLaunch(2'd0);
    applyCoreDone(40);
    stepClock();
    checkCount++; if (done4 !== 1'b1 || cyc0s !== 4'd15) begin errorCount++; $display("[TB] FAIL sat_cyc: got done=%0b cyc0=%0d want 1/15", done4, cyc0s); end
    checkCount++; if (cyc0 !== 16'd40) begin errorCount++; $display("[TB] FAIL sat_wide_cyc: got %0d want 40", cyc0); end
  endtask

  task automatic test_stale_done();
    core_done = 1'b1;
    stepClock();
    applyLaunch(2'd0);
    checkCount++; if (core_start !== 1'b1 || busy !== 1'b1) begin errorCount++; $display("[TB] FAIL stale_launch: got start=%0b busy=%0b want 1/1", core_start, busy); end
    stepClock();
    stepClock();
    stepClock();
    core_done = 1'b0;
    checkCount++; if (done !== 1'b1 || cyc0 !== 16'd1 || cyc0s !== 4'd1) begin errorCount++; $display("[TB] FAIL stale_cyc: got done=%0b cyc0=%0d cyc0s=%0d want 1/1/1", done, cyc0, cyc0s); end
  endtask

  task automatic test_reset_mid_run();
    applyLaunch(2'd3);
    applyCoreDone(5);
    stepClock();
    checkCount++; if (core_start !== 1'b1 || prog_idx !== 2'd1 || start_pc !== 10'd64) begin errorCount++; $display("[TB] FAIL midrst_prog2: got start=%0b idx=%0d pc=%0d want 1/1/64", core_start, prog_idx, start_pc); end
    stepClock();
    stepClock();
    reset = 1'b0;
    stepClock();
    reset = 1'b1;
    checkCount++; if (busy !== 1'b0 || done !== 1'b0 || core_start !== 1'b0 || prog_idx !== 2'd0 || start_pc !== 10'd0) begin errorCount++; $display("[TB] FAIL midrst_ctrl: got busy=%0b done=%0b start=%0b idx=%0d pc=%0d want 0/0/0/0/0", busy, done, core_start, prog_idx, start_pc); end
    checkCount++; if (cyc0 !== 16'd0 || cyc1 !== 16'd0 || cyc2 !== 16'd0) begin errorCount++; $display("[TB] FAIL midrst_cyc: got %0d/%0d/%0d want 0/0/0", cyc0, cyc1, cyc2); end
    core_done = 1'b1;
    repeat (3) stepClock();
    core_done = 1'b0;
    checkCount++; if (done !== 1'b0 || busy !== 1'b0 || cyc1 !== 16'd0) begin errorCount++; $display("[TB] FAIL midrst_ignore: got done=%0b busy=%0b cyc1=%0d want 0/0/0", done, busy, cyc1); end
  endtask

  // Scenario sequence; later tasks rely on the cycle counts left by earlier ones.
  initial begin
    test_reset();
    test_single();
    test_run_all();
    test_ignored_init();
    test_relaunch();
    test_saturation();
    test_stale_done();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, errorCount);
    $finish;
  end

endmodule
